// File: rtl/pkt_rr_scheduler_pkg.sv
// Shared types and helpers for the packet round-robin scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_rr_scheduler_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PKT  = 1'b1
  } state_t;

  localparam int CNT_W = 32;

  // Ceiling log2 with a floor of 1, so a 2-port build still gets a 1-bit index.
  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_rr_scheduler_rr_priority_encoder.sv
// Round-robin pick: first requester strictly after the last-served port, modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is registered.
import pkt_rr_scheduler_pkg::*;

module rr_priority_encoder #(
  parameter int N  = 5,
  parameter int LW = log2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // Walk the rotated request vector from the farthest offset to the nearest, so
  // the nearest requester after 'last' overwrites any earlier hit and wins.
  always_comb begin
    int          idx;
    logic [LW-1:0] sel;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = N; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (idx >= N) idx = idx - N;
      sel = LW'(idx);
      if (req[sel]) begin
        gnt_idx   = sel;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-granular round-robin merge of N AXI4-Stream ingress ports onto one egress port.
// Latency: one IDLE bubble per packet to register the grant, then zero-latency pass-through.
// Backpressure: m_axis_tready is routed straight to the granted port's tready; others see 0.
import pkt_rr_scheduler_pkg::*;

module pkt_rr_scheduler #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_NUM_INPUT_IF     = 5
) (
  input  logic                                             axi_aclk,
  input  logic                                             axi_aresetn,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb_grp,
  input  logic [C_S_NUM_INPUT_IF*C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                       s_axis_tvalid_grp,
  output logic [C_S_NUM_INPUT_IF-1:0]                       s_axis_tready_grp,
  input  logic [C_S_NUM_INPUT_IF-1:0]                       s_axis_tlast_grp,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]                  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]                   m_axis_tuser,
  output logic                                             m_axis_tvalid,
  input  logic                                             m_axis_tready,
  output logic                                             m_axis_tlast,
  input  logic [C_S_NUM_INPUT_IF-1:0]                       port_enable,
  input  logic                                             sw_rst,
  output logic [C_S_NUM_INPUT_IF*CNT_W-1:0]                 pkt_cnt_grp,
  output logic [C_S_NUM_INPUT_IF-1:0]                       grant_oh
);

  localparam int N  = C_S_NUM_INPUT_IF;
  localparam int DW = C_M_AXIS_DATA_WIDTH;
  localparam int SW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_M_AXIS_TUSER_WIDTH;
  localparam int LW = log2(N);

  state_t            state, state_nxt;
  logic [LW-1:0]     grant_idx, grant_idx_nxt;
  logic [N-1:0]      grant_oh_q, grant_oh_nxt;
  logic [LW-1:0]     last_port, last_port_nxt;
  logic [N*CNT_W-1:0] pkt_cnt_q;
  logic              pkt_done;
  logic [LW-1:0]     enc_idx;
  logic              enc_valid;

  // Enable is only consulted here, so dropping it mid-packet cannot cut a packet short.
  rr_priority_encoder #(
    .N  (N),
    .LW (LW)
  ) u_enc (
    .req       (s_axis_tvalid_grp & port_enable),
    .last      (last_port),
    .gnt_idx   (enc_idx),
    .gnt_valid (enc_valid)
  );

  // Next-state: latch a grant in IDLE, release it on the accepted tlast beat.
  always_comb begin
    state_nxt     = state;
    grant_idx_nxt = grant_idx;
    grant_oh_nxt  = grant_oh_q;
    last_port_nxt = last_port;
    pkt_done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enc_valid) begin
          state_nxt     = S_PKT;
          grant_idx_nxt = enc_idx;
          grant_oh_nxt  = '0;
          for (int i = 0; i < N; i++) begin
            if (enc_idx == LW'(i)) grant_oh_nxt[i] = 1'b1;
          end
        end
      end
      S_PKT: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          pkt_done      = 1'b1;
          last_port_nxt = grant_idx;
          grant_oh_nxt  = '0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, grant and counter registers; soft reset behaves exactly like the async one.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state      <= S_IDLE;
      grant_idx  <= '0;
      grant_oh_q <= '0;
      last_port  <= LW'(N - 1);
      pkt_cnt_q  <= '0;
    end else if (sw_rst) begin
      state      <= S_IDLE;
      grant_idx  <= '0;
      grant_oh_q <= '0;
      last_port  <= LW'(N - 1);
      pkt_cnt_q  <= '0;
    end else begin
      state      <= state_nxt;
      grant_idx  <= grant_idx_nxt;
      grant_oh_q <= grant_oh_nxt;
      last_port  <= last_port_nxt;
      for (int i = 0; i < N; i++) begin
        if (pkt_done && (grant_idx == LW'(i))) begin
          pkt_cnt_q[i*CNT_W +: CNT_W] <= pkt_cnt_q[i*CNT_W +: CNT_W] + 32'd1;
        end
      end
    end
  end

  // Egress mux: pass the granted port through untouched while a packet is open.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tstrb  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == LW'(i)) begin
        m_axis_tdata  = s_axis_tdata_grp[i*DW +: DW];
        m_axis_tstrb  = s_axis_tstrb_grp[i*SW +: SW];
        m_axis_tuser  = s_axis_tuser_grp[i*UW +: UW];
        m_axis_tlast  = s_axis_tlast_grp[i];
        m_axis_tvalid = (state == S_PKT) && s_axis_tvalid_grp[i];
      end
    end
  end

  // Ready demux: depends only on the grant and downstream ready, never on ingress valid.
  always_comb begin
    s_axis_tready_grp = '0;
    if (state == S_PKT) s_axis_tready_grp = grant_oh_q & {N{m_axis_tready}};
  end

  assign grant_oh    = grant_oh_q;
  assign pkt_cnt_grp = pkt_cnt_q;

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
`timescale 1ns/1ps
module tb_pkt_rr_scheduler;

  localparam int N  = 5;
  localparam int DW = 256;
  localparam int UW = 128;

  logic              axi_aclk = 1'b0;
  logic              axi_aresetn;
  logic [N*DW-1:0]   s_axis_tdata_grp;
  logic [N*DW/8-1:0] s_axis_tstrb_grp;
  logic [N*UW-1:0]   s_axis_tuser_grp;
  logic [N-1:0]      s_axis_tvalid_grp;
  logic [N-1:0]      s_axis_tready_grp;
  logic [N-1:0]      s_axis_tlast_grp;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic [N-1:0]      port_enable;
  logic              sw_rst;
  logic [N*32-1:0]   pkt_cnt_grp;
  logic [N-1:0]      grant_oh;

  pkt_rr_scheduler dut (
    .axi_aclk          (axi_aclk),
    .axi_aresetn       (axi_aresetn),
    .s_axis_tdata_grp  (s_axis_tdata_grp),
    .s_axis_tstrb_grp  (s_axis_tstrb_grp),
    .s_axis_tuser_grp  (s_axis_tuser_grp),
    .s_axis_tvalid_grp (s_axis_tvalid_grp),
    .s_axis_tready_grp (s_axis_tready_grp),
    .s_axis_tlast_grp  (s_axis_tlast_grp),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tstrb      (m_axis_tstrb),
    .m_axis_tuser      (m_axis_tuser),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tlast      (m_axis_tlast),
    .port_enable       (port_enable),
    .sw_rst            (sw_rst),
    .pkt_cnt_grp       (pkt_cnt_grp),
    .grant_oh          (grant_oh)
  );

  always #5 axi_aclk = ~axi_aclk;

  int checks   = 0;
  int failures = 0;

  // Per-port source state.
  bit act [N];
  bit cont [N];
  bit hold_v [N];
  int len [N];
  int beat [N];
  int seq [N];

  bit toggle_rdy = 0;
  bit rdy_chk    = 0;
  int nbeats     = 0;
  int nlast      = 0;
  int order [$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int p, input int s, input int b);
    logic [31:0] w;
    w = {p[7:0], s[7:0], b[15:0]};
    return {8{w}};
  endfunction

  function automatic logic [UW-1:0] usr(input int p, input int s, input int b);
    logic [31:0] w;
    w = {p[7:0], s[7:0], b[15:0]} ^ 32'hA5A5_5A5A;
    return {4{w}};
  endfunction

  function automatic logic [DW/8-1:0] strb(input int p);
    return 32'hFFFF_FFFF ^ (32'h1 << p);
  endfunction

  function automatic logic [31:0] cnt(input int p);
    logic [N*32-1:0] v;
    v = pkt_cnt_grp;
    return v[p*32 +: 32];
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid_grp[i]           = act[i] & ~hold_v[i];
      s_axis_tlast_grp[i]            = (beat[i] == len[i] - 1);
      s_axis_tdata_grp[i*DW +: DW]   = pat(i, seq[i], beat[i]);
      s_axis_tuser_grp[i*UW +: UW]   = usr(i, seq[i], beat[i]);
      s_axis_tstrb_grp[i*32 +: 32]   = strb(i);
    end
  endtask

  task automatic start_pkt(input int p, input int l);
    act[p]  = 1;
    len[p]  = l;
    beat[p] = 0;
    drive();
  endtask

  task automatic kill();
    for (int i = 0; i < N; i++) begin
      act[i] = 0; cont[i] = 0; hold_v[i] = 0; beat[i] = 0;
    end
    drive();
  endtask

  // One clock: observe at the falling edge, update sources just after the rising edge.
  task automatic cycle();
    logic [N-1:0] fire;
    int p;
    @(negedge axi_aclk);
    fire = s_axis_tvalid_grp & s_axis_tready_grp;
    if (rdy_chk && grant_oh == 5'b00100)
      check_eq("rdy_demux", s_axis_tready_grp, 5'b00100 & {N{m_axis_tready}});
    if (m_axis_tvalid && m_axis_tready) begin
      p = -1;
      for (int i = 0; i < N; i++) if (fire[i]) p = i;
      check_eq("fire_onehot", $countones(fire), 1);
      if (p >= 0) begin
        check_eq("egress_port", grant_oh, 5'b1 << p);
        check_eq("egress_data", m_axis_tdata == pat(p, seq[p], beat[p]), 1);
        check_eq("egress_user", m_axis_tuser == usr(p, seq[p], beat[p]), 1);
        check_eq("egress_strb", m_axis_tstrb, strb(p));
        check_eq("egress_last", m_axis_tlast, beat[p] == len[p] - 1);
        nbeats++;
        if (m_axis_tlast) begin
          nlast++;
          order.push_back(p);
        end
      end
    end
    @(posedge axi_aclk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        beat[i]++;
        if (beat[i] >= len[i]) begin
          beat[i] = 0;
          seq[i]++;
          act[i]  = cont[i];
        end
      end
    end
    if (toggle_rdy) m_axis_tready = ~m_axis_tready;
    drive();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = 0;
      for (int i = 0; i < N; i++) if (act[i]) busy = 1;
    end
    check_eq(tag, busy, 0);
  endtask

  initial begin
    int n;
    int b0, l0;
    bit held;
    logic [N*32-1:0] preload;

    axi_aresetn   = 1'b0;
    sw_rst        = 1'b0;
    m_axis_tready = 1'b1;
    port_enable   = '1;
    kill();
    repeat (3) @(posedge axi_aclk);
    #1;
    check_eq("rst_grant", grant_oh, 0);
    check_eq("rst_mvalid", m_axis_tvalid, 0);
    check_eq("rst_sready", s_axis_tready_grp, 0);
    check_eq("rst_cnt", pkt_cnt_grp, 0);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;

    // 1: five simultaneous 3-beat packets, 4 cycles each.
    for (int i = 0; i < N; i++) start_pkt(i, 3);
    n = 0;
    while (order.size() < 5 && n < 40) begin cycle(); n++; end
    check_eq("t1_cycles", n, 20);
    check_eq("t1_npkts", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++) check_eq("t1_order", order[i], i);
    for (int i = 0; i < N; i++) check_eq("t1_cnt", cnt(i), 1);
    cycle();
    check_eq("t1_idle_grant", grant_oh, 0);

    // 2: make port 1 the last served, then ports 1 and 3 stream continuously.
    start_pkt(1, 1);
    drain("t2_pre_drain", 10);
    order.delete();
    cont[1] = 1; cont[3] = 1;
    start_pkt(1, 2);
    start_pkt(3, 2);
    n = 0;
    while (order.size() < 4 && n < 40) begin cycle(); n++; end
    check_eq("t2_npkts", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) check_eq("t2_order", order[i], (i % 2 == 0) ? 3 : 1);
    cont[1] = 0; cont[3] = 0;
    drain("t2_drain", 40);

    // 3: 8-beat packet on port 2 with toggling downstream ready and a valid gap.
    order.delete();
    b0 = nbeats;
    rdy_chk = 1;
    toggle_rdy = 1;
    held = 0;
    start_pkt(2, 8);
    n = 0;
    while (order.size() < 1 && n < 80) begin
      if (beat[2] == 4 && !held) begin
        hold_v[2] = 1;
        drive();
        repeat (3) begin
          cycle();
          check_eq("t3_hold_grant", grant_oh, 5'b00100);
          check_eq("t3_hold_mvalid", m_axis_tvalid, 0);
        end
        hold_v[2] = 0;
        drive();
        held = 1;
      end
      cycle();
      n++;
    end
    rdy_chk = 0;
    toggle_rdy = 0;
    m_axis_tready = 1'b1;
    check_eq("t3_beats", nbeats - b0, 8);
    check_eq("t3_cnt2", cnt(2), 2);

    // 4: a disabled requester is never granted; enable changes mid-packet are ignored.
    order.delete();
    port_enable = 5'b11110;
    start_pkt(0, 2);
    repeat (8) cycle();
    check_eq("t4_no_grant", grant_oh, 0);
    check_eq("t4_no_ready", s_axis_tready_grp, 0);
    check_eq("t4_no_pkts", order.size(), 0);
    start_pkt(1, 4);
    n = 0;
    while (grant_oh != 5'b00010 && n < 10) begin cycle(); n++; end
    check_eq("t4_grant1", grant_oh, 5'b00010);
    port_enable = 5'b11100;
    n = 0;
    while (order.size() < 1 && n < 20) begin cycle(); n++; end
    check_eq("t4_pkt_done", order.size(), 1);
    if (order.size() > 0) check_eq("t4_pkt_port", order[0], 1);
    start_pkt(1, 1);
    repeat (8) cycle();
    check_eq("t4_no_regrant", grant_oh, 0);
    check_eq("t4_still_one", order.size(), 1);
    kill();
    port_enable = '1;

    // 5: soft reset mid-packet, then asynchronous reset between edges.
    start_pkt(3, 4);
    n = 0;
    while (beat[3] != 2 && n < 20) begin cycle(); n++; end
    check_eq("t5_reach_beat2", beat[3], 2);
    sw_rst = 1'b1;
    cycle();
    sw_rst = 1'b0;
    check_eq("t5_sw_grant", grant_oh, 0);
    check_eq("t5_sw_cnt", pkt_cnt_grp, 0);
    check_eq("t5_sw_mvalid", m_axis_tvalid, 0);
    kill();
    start_pkt(2, 1);
    drain("t5_drain", 10);
    start_pkt(2, 4);
    cycle();
    cycle();
    check_eq("t5_pre_grant", grant_oh, 5'b00100);
    check_eq("t5_pre_cnt2", cnt(2), 1);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check_eq("t5_arst_grant", grant_oh, 0);
    check_eq("t5_arst_cnt", pkt_cnt_grp, 0);
    check_eq("t5_arst_mvalid", m_axis_tvalid, 0);
    check_eq("t5_arst_sready", s_axis_tready_grp, 0);
    kill();
    @(negedge axi_aclk);
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(posedge axi_aclk);
    #1;

    // 6: counter wrap on a single-beat packet.
    preload = '0;
    preload[4*32 +: 32] = 32'hFFFF_FFFF;
    force dut.pkt_cnt_q = preload;
    #1;
    release dut.pkt_cnt_q;
    check_eq("t6_preload", cnt(4), 32'hFFFF_FFFF);
    order.delete();
    b0 = nbeats;
    l0 = nlast;
    start_pkt(4, 1);
    drain("t6_drain", 10);
    check_eq("t6_wrap", cnt(4), 0);
    check_eq("t6_beats", nbeats - b0, 1);
    check_eq("t6_lasts", nlast - l0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
